imem_server: RTL and testbench
==============================

IMEM_SERVER -- requirements
Module: imem_server

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset. Ports: iclk input 1, rising-edge clock; reset_n input 1, asynchronous active-low reset.
REQ-002 SHALL have the fetch request port:
- req_valid input 1: fetch request present.
- req_ready output 1: request can be accepted.
- req_addr input 10: byte address; word index is [9:2].
REQ-003 SHALL have the fetch response port:
- rsp_valid output 1: response present.
- rsp_ready input 1: requester accepts response.
- rsp_data output 32: instruction word.
- rsp_addr output 10: address of the request being answered.
- rsp_err output 1: misaligned request.
REQ-004 SHALL have the control and load ports:
- flush input 1: discard all outstanding work (branch/jump redirect).
- ld_en input 1: program-load write strobe.
- ld_addr input 8: word index.
- ld_data input 32: word to write.
- rsp_cnt output 16: completed-response counter.

Function
REQ-005 SHALL contain 256 x 32-bit storage, written only through the load port.
REQ-006 SHALL define a request handshake as req_valid && req_ready sampled at a rising iclk edge, and a response handshake as rsp_valid && rsp_ready sampled at a rising iclk edge.
REQ-007 SHALL read the storage at the request-handshake edge, so a later load never alters that response.
REQ-008 SHALL place each accepted request into a 2-entry response FIFO holding data, addr and err. rsp_valid SHALL assert the cycle after the handshake, giving 1-cycle latency when the FIFO is empty.
REQ-009 SHALL drive rsp_data/rsp_addr/rsp_err from the FIFO head and hold them stable while rsp_valid=1 and rsp_ready=0.
REQ-010 SHALL drive req_ready = !ld_en && !flush && (fifo_count < 2, counting an entry that pops in the same cycle as free). Simultaneous push and pop at count 2 SHALL therefore be allowed, giving full throughput of 1 response/cycle.
REQ-011 SHALL handle misaligned requests (req_addr[1:0] != 0) as follows: accept them, then respond with rsp_err=1 and rsp_data=0.
REQ-012 SHALL return responses strictly in request order.
REQ-013 SHALL give flush=1 these effects at the next edge:
- empty the FIFO.
- suppress any push and any pop that edge.
- leave rsp_valid=0 on the following cycle.
- leave rsp_cnt unchanged by the dropped entries.
REQ-014 SHALL write ld_data to entry ld_addr at the edge when ld_en=1. ld_en SHALL NOT disturb FIFO contents or an in-progress response.
REQ-015 SHALL increment rsp_cnt by 1 on each response handshake, wrapping modulo 2^16 (0xFFFF -> 0x0000).
REQ-016 SHALL give flush priority when flush and ld_en occur together: the load write still occurs, and the FIFO is emptied.

Reset
REQ-017 SHALL, on reset_n low, immediately drive:
- rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0.
- rsp_cnt=0.
- an empty FIFO.
- req_ready=0 while reset_n is low.
REQ-018 SHALL NOT clear storage contents on reset. Reset asserted mid-transaction SHALL discard all pending responses.
REQ-019 SHALL allow req_ready to assert in the first cycle after reset_n deasserts (subject to REQ-010).

Verification
REQ-020 Load then fetch: load word 5 = 0x8C010004, then request addr 0x014 -> next cycle rsp_valid=1, rsp_data=0x8C010004, rsp_addr=0x014, rsp_err=0.
REQ-021 Back-to-back fetch with rsp_ready=1: requests 0x000, 0x004, 0x008 on consecutive cycles -> three responses on consecutive cycles, in order, rsp_cnt=3.
REQ-022 Backpressure: rsp_ready=0 with 3 requests offered -> 2 accepted, req_ready=0 on the third, outputs stable. Then rsp_ready=1 -> the third request is accepted as the head pops.
REQ-023 Flush: 2 entries pending, assert flush for 1 cycle -> FIFO empty, rsp_valid=0, rsp_cnt unchanged, next request answered normally.
REQ-024 Misaligned and load interaction:
- request 0x006 -> rsp_err=1, rsp_data=0.
- ld_en=1 with req_valid=1 -> req_ready=0, write completes, request accepted the cycle after ld_en drops.
REQ-025 Counter wrap and reset: preset traffic to rsp_cnt=0xFFFF, then one handshake -> 0x0000. reset_n low mid-stream -> rsp_valid=0 immediately, storage retained.

Source files
------------

// File: rtl/imem_server.sv
// Instruction memory server: 256x32 program store with a 2-entry in-order fetch response FIFO.
// Loads come through a dedicated write port; flush drops all outstanding responses.
module imem_server (
    input  logic        iclk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [9:0]  rsp_addr,
    output logic        rsp_err,
    input  logic        flush,
    input  logic        ld_en,
    input  logic [7:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic [15:0] rsp_cnt
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned CNT_W  = 16;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } rsp_t;

    logic [DATA_W-1:0] mem [DEPTH];
    rsp_t              fifo_q [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic              push;
    logic              pop;
    rsp_t              entry;

    // Handshake decode; a slot popping this cycle counts as free for the incoming request.
    always_comb begin
        entry     = '0;
        pop       = (count != 2'd0) && rsp_ready && !flush;
        req_ready = reset_n && !ld_en && !flush && ((count != 2'd2) || rsp_ready);
        push      = req_valid && req_ready;
        entry.addr = req_addr;
        entry.err  = (req_addr[1:0] != 2'b00);
        entry.data = entry.err ? '0 : mem[req_addr[9:2]];
    end

    // Program store: written only by the load port, never reset.
    always_ff @(posedge iclk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge iclk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
            rsp_cnt   <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= entry;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                rsp_cnt <= CNT_W'(rsp_cnt + CNT_W'(1));
            end
            case ({push, pop})
                2'b10:   count <= 2'(count + 2'd1);
                2'b01:   count <= 2'(count - 2'd1);
                default: count <= count;
            endcase
        end
    end

    // Head of the FIFO drives the response; it only moves on a pop.
    assign rsp_valid = (count != 2'd0);
    assign rsp_data  = fifo_q[rd_ptr].data;
    assign rsp_addr  = fifo_q[rd_ptr].addr;
    assign rsp_err   = fifo_q[rd_ptr].err;

endmodule

// File: tb/tb_imem_server.sv
// Self-checking bench for imem_server: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_imem_server;

    logic        iclk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [9:0]  rsp_addr;
    logic        rsp_err;
    logic        flush;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic [15:0] rsp_cnt;

    typedef struct packed {
        logic [31:0] d;
        logic [9:0]  a;
        logic        e;
    } rsp_t;

    rsp_t        mq[$];
    logic [31:0] mmem [256];
    logic [15:0] mcnt;
    int          n_checks = 0;
    int          n_errors = 0;

    imem_server dut (
        .iclk      (iclk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .rsp_cnt   (rsp_cnt)
    );

    always #5 iclk = ~iclk;

    // Reference model: acceptance rule is "not loading, not flushing, and room once any pop is counted".
    function automatic logic model_ready();
        return reset_n && !ld_en && !flush && ((mq.size() < 2) || rsp_ready);
    endfunction

    task automatic drive(input logic rv, input logic [9:0] ra, input logic rr,
                         input logic fl, input logic ld, input logic [7:0] la, input logic [31:0] ldd);
        req_valid = rv;
        req_addr  = ra;
        rsp_ready = rr;
        flush     = fl;
        ld_en     = ld;
        ld_addr   = la;
        ld_data   = ldd;
        #1;
    endtask

    task automatic tick();
        logic rdy;
        logic pop;
        logic push;
        rsp_t n;
        rdy  = model_ready();
        pop  = (mq.size() > 0) && rsp_ready && !flush;
        push = req_valid && rdy;
        n.a  = req_addr;
        n.e  = (req_addr[1:0] != 2'b00);
        n.d  = n.e ? 32'h0 : mmem[req_addr[9:2]];
        @(posedge iclk);
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                mcnt = mcnt + 16'd1;
            end
            if (push) mq.push_back(n);
        end
        if (ld_en) mmem[ld_addr] = ld_data;
        @(negedge iclk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        mcnt    = 16'h0;
        drive(1'b1, 10'h000, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        #2;
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_data !== 32'h0) begin n_errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        n_checks++; if (rsp_addr !== 10'h0) begin n_errors++; $display("FAIL reset_rsp_addr: got %h want 0", rsp_addr); end
        n_checks++; if (rsp_err !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        n_checks++; if (rsp_cnt !== 16'h0) begin n_errors++; $display("FAIL reset_rsp_cnt: got %h want 0", rsp_cnt); end
        n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        @(negedge iclk);
        @(negedge iclk);
        reset_n = 1'b1;
        drive(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_preload();
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 8'(i), $urandom);
            tick();
        end
    endtask

    task automatic test_load_fetch();
        drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 8'd5, 32'h8C010004);
        tick();
        drive(1'b1, 10'h014, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL lf_req_ready: got %b want 1", req_ready); end
        tick();
        drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
        n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL lf_rsp_valid: got %b want 1", rsp_valid); end
        n_checks++; if (rsp_data !== 32'h8C010004) begin n_errors++; $display("FAIL lf_rsp_data: got %h want 8c010004", rsp_data); end
        n_checks++; if (rsp_addr !== 10'h014) begin n_errors++; $display("FAIL lf_rsp_addr: got %h want 014", rsp_addr); end
        n_checks++; if (rsp_err !== 1'b0) begin n_errors++; $display("FAIL lf_rsp_err: got %b want 0", rsp_err); end
        drive(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
        tick();
        n_checks++; if (rsp_cnt !== 16'd1) begin n_errors++; $display("FAIL lf_rsp_cnt: got %0d want 1", rsp_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] cnt0;
        logic [9:0]  addrs [3];
        addrs[0] = 10'h000; addrs[1] = 10'h004; addrs[2] = 10'h008;
        cnt0 = mcnt;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, addrs[i], 1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
            n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready); end
            tick();
            n_checks++; if (rsp_valid !== 1'b1 || rsp_addr !== addrs[i] || rsp_data !== mmem[i])
                begin n_errors++; $display("FAIL b2b_rsp[%0d]: got v=%b a=%h d=%h want v=1 a=%h d=%h", i, rsp_valid, rsp_addr, rsp_data, addrs[i], mmem[i]); end
        end
        drive(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
        tick();
        n_checks++; if (rsp_cnt !== 16'(cnt0 + 16'd3)) begin n_errors++; $display("FAIL b2b_cnt: got %0d want %0d", rsp_cnt, cnt0 + 16'd3); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drained: got %b want 0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 10'h010, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0); tick();
        drive(1'b1, 10'h014, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL bp_second_ready: got %b want 1", req_ready); end
        tick();
        drive(1'b1, 10'h018, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL bp_full_ready[%0d]: got %b want 0", i, req_ready); end
            n_checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 10'h010 || rsp_data !== mmem[4])
                begin n_errors++; $display("FAIL bp_hold[%0d]: got v=%b a=%h d=%h want v=1 a=010 d=%h", i, rsp_valid, rsp_addr, rsp_data, mmem[4]); end
            tick();
        end
        drive(1'b1, 10'h018, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL bp_pop_frees: got %b want 1", req_ready); end
        tick();
        drive(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
        n_checks++; if (rsp_addr !== 10'h014) begin n_errors++; $display("FAIL bp_order1: got %h want 014", rsp_addr); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 10'h018 || rsp_data !== mmem[6])
            begin n_errors++; $display("FAIL bp_order2: got v=%b a=%h d=%h want v=1 a=018 d=%h", rsp_valid, rsp_addr, rsp_data, mmem[6]); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drained: got %b want 0", rsp_valid); end
    endtask

    task automatic test_flush();
        logic [15:0] cnt0;
        drive(1'b1, 10'h020, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0); tick();
        drive(1'b1, 10'h024, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0); tick();
        cnt0 = mcnt;
        drive(1'b1, 10'h028, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0);
        n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready: got %b want 0", req_ready); end
        tick();
        drive(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL flush_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_cnt !== cnt0) begin n_errors++; $display("FAIL flush_cnt: got %0d want %0d", rsp_cnt, cnt0); end
        drive(1'b1, 10'h028, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0); tick();
        drive(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 10'h028 || rsp_data !== mmem[10])
            begin n_errors++; $display("FAIL flush_after: got v=%b a=%h d=%h want v=1 a=028 d=%h", rsp_valid, rsp_addr, rsp_data, mmem[10]); end
        tick();
    endtask

    task automatic test_misaligned_load();
        logic [31:0] w;
        drive(1'b1, 10'h006, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0); tick();
        drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0 || rsp_addr !== 10'h006)
            begin n_errors++; $display("FAIL misaligned: got v=%b e=%b d=%h a=%h want v=1 e=1 d=0 a=006", rsp_valid, rsp_err, rsp_data, rsp_addr); end
        drive(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0); tick();
        w = $urandom;
        drive(1'b1, 10'h030, 1'b1, 1'b0, 1'b1, 8'd12, w);
        n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL ld_blocks_ready: got %b want 0", req_ready); end
        tick();
        drive(1'b1, 10'h030, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL ld_release_ready: got %b want 1", req_ready); end
        tick();
        drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== w) begin n_errors++; $display("FAIL ld_then_fetch: got v=%b d=%h want v=1 d=%h", rsp_valid, rsp_data, w); end
        w = $urandom;
        drive(1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 8'd13, w); tick();
        drive(1'b1, 10'h034, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL flush_ld_valid: got %b want 0", rsp_valid); end
        tick();
        drive(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== w) begin n_errors++; $display("FAIL flush_ld_write: got v=%b d=%h want v=1 d=%h", rsp_valid, rsp_data, w); end
        tick();
    endtask

    task automatic test_random();
        logic [9:0] ra;
        for (int i = 0; i < 400; i++) begin
            ra = 10'($urandom);
            if ($urandom_range(0, 4) != 0) ra[1:0] = 2'b00;
            drive(1'($urandom), ra, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 7) == 0), 8'($urandom), $urandom);
            n_checks++; if (req_ready !== model_ready()) begin n_errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, req_ready, model_ready()); end
            n_checks++; if (rsp_valid !== (mq.size() > 0)) begin n_errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, rsp_valid, mq.size() > 0); end
            n_checks++; if (rsp_cnt !== mcnt) begin n_errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, rsp_cnt, mcnt); end
            if (mq.size() > 0) begin
                n_checks++; if ({rsp_data, rsp_addr, rsp_err} !== mq[0])
                    begin n_errors++; $display("FAIL rnd_head[%0d]: got d=%h a=%h e=%b want d=%h a=%h e=%b", i, rsp_data, rsp_addr, rsp_err, mq[0].d, mq[0].a, mq[0].e); end
            end
            tick();
        end
        drive(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
        tick(); tick();
    endtask

    task automatic test_counter_wrap();
        while (mcnt != 16'hFFFF) begin
            drive(1'b1, {8'($urandom), 2'b00}, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
            tick();
        end
        drive(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
        n_checks++; if (rsp_cnt !== 16'hFFFF) begin n_errors++; $display("FAIL wrap_pre: got %h want ffff", rsp_cnt); end
        n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL wrap_pending: got %b want 1", rsp_valid); end
        tick();
        n_checks++; if (rsp_cnt !== 16'h0000) begin n_errors++; $display("FAIL wrap_post: got %h want 0000", rsp_cnt); end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 10'h040, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0); tick();
        drive(1'b1, 10'h044, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0); tick();
        drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
        #1;
        reset_n = 1'b0;
        mq.delete();
        mcnt = 16'h0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_valid: got %b want 0", rsp_valid); end
        n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL midreset_ready: got %b want 0", req_ready); end
        @(negedge iclk);
        reset_n = 1'b1;
        drive(1'b1, 10'h014, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0); tick();
        drive(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h8C010004) begin n_errors++; $display("FAIL storage_retained: got v=%b d=%h want v=1 d=8c010004", rsp_valid, rsp_data); end
        tick();
        n_checks++; if (rsp_cnt !== 16'd1) begin n_errors++; $display("FAIL midreset_cnt: got %0d want 1", rsp_cnt); end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_load_fetch();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_misaligned_load();
        test_random();
        test_counter_wrap();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
